axis_rx_packer: RTL

Ingress stage between the 256-bit AXI-Stream receive port and the split 1048-bit receive FIFO (1024-bit wide FIFO plus 24-bit side FIFO, both written with one shared write enable). Collects up to four stream beats into one 1048-bit packet word: 1024 payload bits plus a 24-bit descriptor. Writes that word into the receive FIFO, where the RV32IN core reads it as one unit. Applies backpressure while a word waits on a full FIFO, and truncates packets longer than four beats.

---
 rtl/axis_rx_packer.sv | 103 ++++++++++
 1 files changed

// File: rtl/axis_rx_packer.sv
// axis_rx_packer: packs up to four 256-bit stream beats plus a 24-bit descriptor into one 1048-bit receive FIFO word
module axis_rx_packer (
  input  logic          clk,
  input  logic          rst,
  input  logic [255:0]  rdata,
  input  logic [31:0]   rkeep,
  input  logic [127:0]  ruser,
  input  logic          rvalid,
  output logic          rready,
  input  logic          rlast,
  input  logic          rxfifofull,
  output logic          rxfifowe,
  output logic [1047:0] rx_fifo_in,
  output logic [15:0]   pkt_count,
  output logic [15:0]   trunc_count
);
  typedef enum logic [1:0] {COLLECT, DRAIN, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1023:0] payload_q, payload_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    tag_q, tag_d;
  logic [2:0]    beats_q, beats_d;
  logic          trunc_q, trunc_d;
  logic [15:0]   pkt_q, pkt_d;
  logic [15:0]   trc_q, trc_d;
  logic [255:0]  masked;
  logic [5:0]    keep_cnt;
  logic          acc;
  logic          unused_ok;
  assign unused_ok   = ^ruser[127:8];
  assign rready      = !rst && state_q != FLUSH;
  assign rxfifowe    = !rst && state_q == FLUSH && !rxfifofull;
  assign acc         = rvalid && rready;
  assign rx_fifo_in  = {payload_q, count_q, tag_q, beats_q, trunc_q, 4'b0};
  assign pkt_count   = pkt_q;
  assign trunc_count = trc_q;
  always_comb begin
    masked   = '0;
    keep_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      masked[8*i +: 8] = rkeep[i] ? rdata[8*i +: 8] : 8'h00;
      keep_cnt         = keep_cnt + 6'(rkeep[i]);
    end
  end
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    count_d   = count_q;
    tag_d     = tag_q;
    beats_d   = beats_q;
    trunc_d   = trunc_q;
    pkt_d     = pkt_q;
    trc_d     = trc_q;
    case (state_q)
      COLLECT: if (acc) begin
        // beat 0 starts a fresh word so no stale bytes from the previous packet survive
        if (idx_q == 2'd0) begin
          payload_d = '0;
          tag_d     = ruser[7:0];
        end
        payload_d[{idx_q, 8'b0} +: 256] = masked;
        count_d = (idx_q == 2'd0 ? 8'd0 : count_q) + {2'b0, keep_cnt};
        beats_d = {1'b0, idx_q};
        trunc_d = idx_q == 2'd3 && !rlast;
        idx_d   = idx_q + 2'd1;
        state_d = rlast ? FLUSH : (idx_q == 2'd3 ? DRAIN : COLLECT);
      end
      DRAIN: state_d = acc && rlast ? FLUSH : DRAIN;
      FLUSH: if (rxfifowe) begin
        state_d = COLLECT;
        idx_d   = 2'd0;
        pkt_d   = pkt_q == 16'hFFFF ? pkt_q : pkt_q + 16'd1;
        trc_d   = trunc_q && trc_q != 16'hFFFF ? trc_q + 16'd1 : trc_q;
      end
      default: state_d = COLLECT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      payload_q <= '0;
      count_q   <= '0;
      tag_q     <= '0;
      beats_q   <= '0;
      trunc_q   <= 1'b0;
      pkt_q     <= '0;
      trc_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      count_q   <= count_d;
      tag_q     <= tag_d;
      beats_q   <= beats_d;
      trunc_q   <= trunc_d;
      pkt_q     <= pkt_d;
      trc_q     <= trc_d;
    end
  end
endmodule
